// File: rtl/depacketizer_dta_pkg.sv
// Shared types and width helpers for the flit depacketizer.
// Optional error reporting is enabled with DEPACKETIZER_DTA_ERR_EN.
package depacketizer_dta_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD,
    DISCARD
  } state_t;

  function automatic int flit_data_w(
    input int wp,
    input int aw,
    input int vw
  );
    return wp - 3 - aw - vw;
  endfunction

  function automatic int head_chunk_w(
    input int fd,
    input int tw,
    input int aw,
    input int vw
  );
    return fd - tw - aw - vw;
  endfunction

endpackage

// File: rtl/dta_head_parse.sv
// Combinational field extraction for one incoming flit.
// Head fields are only meaningful when o_head is set.
module dta_head_parse
  import depacketizer_dta_pkg::*;
#(
  parameter int WIDTH_PKT        = 36,
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int TAG_WIDTH        = 8,
  localparam int FLIT_DATA =
    flit_data_w(WIDTH_PKT, ADDRESS_WIDTH,
                VC_ADDRESS_WIDTH),
  localparam int HEAD_CHUNK =
    head_chunk_w(FLIT_DATA, TAG_WIDTH,
                 ADDRESS_WIDTH, VC_ADDRESS_WIDTH)
) (
  input  logic [WIDTH_PKT-1:0]        i_flit,
  output logic                        o_valid,
  output logic                        o_head,
  output logic                        o_tail,
  output logic [TAG_WIDTH-1:0]        o_tag,
  output logic [ADDRESS_WIDTH-1:0]    o_dst,
  output logic [VC_ADDRESS_WIDTH-1:0] o_vc,
  output logic [HEAD_CHUNK-1:0]       o_chunk0,
  output logic [FLIT_DATA-1:0]        o_payload
);

  logic w_unused_route;

  assign o_valid   = i_flit[WIDTH_PKT-1];
  assign o_head    = i_flit[WIDTH_PKT-2];
  assign o_tail    = i_flit[WIDTH_PKT-3];
  assign o_payload = i_flit[FLIT_DATA-1:0];

  // Forward routing fields are consumed upstream by the router.
  assign w_unused_route =
    ^i_flit[WIDTH_PKT-4:FLIT_DATA];

  assign o_tag =
    o_payload[FLIT_DATA-1 -: TAG_WIDTH];
  assign o_dst =
    o_payload[FLIT_DATA-TAG_WIDTH-1 -: ADDRESS_WIDTH];
  assign o_vc =
    o_payload[HEAD_CHUNK +: VC_ADDRESS_WIDTH];
  assign o_chunk0 = o_payload[HEAD_CHUNK-1:0];

endmodule

// File: rtl/depacketizer_dta_n.sv
// Reassembles head/body/tail flits into one payload plus return header.
// Define DEPACKETIZER_DTA_ERR_EN to add err_out and err_count_out.
module depacketizer_dta_n
  import depacketizer_dta_pkg::*;
#(
  parameter int WIDTH_PKT        = 36,
  parameter int WIDTH_DATA       = 99,
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int TAG_WIDTH        = 8,
  parameter int MAX_FLITS        = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH_PKT-1:0]        data_in,
  output logic                        ready_out,
  output logic [WIDTH_DATA-1:0]       data_out,
  output logic [ADDRESS_WIDTH-1:0]    dst_out,
  output logic [VC_ADDRESS_WIDTH-1:0] vc_out,
  output logic [TAG_WIDTH-1:0]        tag_out,
  output logic                        valid_out,
  input  logic                        ready_in
`ifdef DEPACKETIZER_DTA_ERR_EN
  ,
  output logic                        err_out,
  output logic [15:0]                 err_count_out
`endif
);

  localparam int FLIT_DATA =
    flit_data_w(WIDTH_PKT, ADDRESS_WIDTH,
                VC_ADDRESS_WIDTH);
  localparam int HEAD_CHUNK =
    head_chunk_w(FLIT_DATA, TAG_WIDTH,
                 ADDRESS_WIDTH, VC_ADDRESS_WIDTH);
  localparam int BUF_W =
    HEAD_CHUNK + (MAX_FLITS - 1) * FLIT_DATA;
  localparam int CNT_W = $clog2(MAX_FLITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(MAX_FLITS);

  state_t                      r_state;
  state_t                      w_next;
  logic [CNT_W-1:0]            r_cnt;
  logic [CNT_W-1:0]            w_cnt_n;
  logic [CNT_W-1:0]            w_cnt_inc;
  logic [BUF_W-1:0]            r_buf;
  logic [BUF_W-1:0]            w_buf_n;
  logic [WIDTH_DATA-1:0]       w_data_n;
  logic [TAG_WIDTH-1:0]        r_tag;
  logic [TAG_WIDTH-1:0]        w_tag_n;
  logic [ADDRESS_WIDTH-1:0]    r_dst;
  logic [ADDRESS_WIDTH-1:0]    w_dst_n;
  logic [VC_ADDRESS_WIDTH-1:0] r_vc;
  logic [VC_ADDRESS_WIDTH-1:0] w_vc_n;
  logic                        w_load;

  logic [WIDTH_DATA-1:0]       r_data;
  logic [ADDRESS_WIDTH-1:0]    r_dst_o;
  logic [VC_ADDRESS_WIDTH-1:0] r_vc_o;
  logic [TAG_WIDTH-1:0]        r_tag_o;

  logic                        w_valid;
  logic                        w_head;
  logic                        w_tail;
  logic [TAG_WIDTH-1:0]        w_tag;
  logic [ADDRESS_WIDTH-1:0]    w_dst;
  logic [VC_ADDRESS_WIDTH-1:0] w_vc;
  logic [HEAD_CHUNK-1:0]       w_chunk0;
  logic [FLIT_DATA-1:0]        w_payload;
  logic                        w_acc;
  logic                        w_start;

  dta_head_parse #(
    .WIDTH_PKT       (WIDTH_PKT),
    .ADDRESS_WIDTH   (ADDRESS_WIDTH),
    .VC_ADDRESS_WIDTH(VC_ADDRESS_WIDTH),
    .TAG_WIDTH       (TAG_WIDTH)
  ) u_parse (
    .i_flit   (data_in),
    .o_valid  (w_valid),
    .o_head   (w_head),
    .o_tail   (w_tail),
    .o_tag    (w_tag),
    .o_dst    (w_dst),
    .o_vc     (w_vc),
    .o_chunk0 (w_chunk0),
    .o_payload(w_payload)
  );

  assign valid_out = (r_state == HOLD);
  assign ready_out =
    (r_state == HOLD) ? ready_in : 1'b1;
  assign data_out  = r_data;
  assign dst_out   = r_dst_o;
  assign vc_out    = r_vc_o;
  assign tag_out   = r_tag_o;

  assign w_acc     = w_valid & ready_out;
  assign w_cnt_inc = r_cnt + 1'b1;

  // Flits handled as if idle: true idle, held packet
  // leaving this cycle, or a head that restarts.
  assign w_start = w_acc & (
    (r_state == IDLE) |
    (r_state == HOLD) |
    (w_head & ((r_state == COLLECT) |
               (r_state == DISCARD))));

  always_comb begin
    w_next  = r_state;
    w_cnt_n = r_cnt;
    w_buf_n = r_buf;
    w_tag_n = r_tag;
    w_dst_n = r_dst;
    w_vc_n  = r_vc;
    w_load  = 1'b0;
    case (r_state)
      COLLECT: begin
        if (w_acc && !w_head) begin
          for (int s = 1; s < MAX_FLITS; s++) begin
            if (r_cnt == CNT_W'(s)) begin
              w_buf_n[BUF_W-HEAD_CHUNK-(s-1)*FLIT_DATA-1
                      -: FLIT_DATA] = w_payload;
            end
          end
          w_cnt_n = w_cnt_inc;
          if (w_tail) begin
            w_next = HOLD;
            w_load = 1'b1;
          end else if (w_cnt_inc == CNT_MAX) begin
            w_next = DISCARD;
          end
        end
      end
      HOLD: begin
        if (ready_in) w_next = IDLE;
      end
      DISCARD: begin
        if (w_acc && !w_head && w_tail)
          w_next = IDLE;
      end
      default: ;
    endcase
    if (w_start) begin
      unique case (1'b1)
        (!w_head): begin
          w_next  = IDLE;
          w_cnt_n = '0;
        end
        (w_head && w_tail): begin
          w_buf_n = '0;
          w_buf_n[BUF_W-1 -: HEAD_CHUNK] = w_chunk0;
          w_tag_n = w_tag;
          w_dst_n = w_dst;
          w_vc_n  = w_vc;
          w_cnt_n = CNT_W'(1);
          w_next  = HOLD;
          w_load  = 1'b1;
        end
        (w_head && !w_tail): begin
          w_buf_n = '0;
          w_buf_n[BUF_W-1 -: HEAD_CHUNK] = w_chunk0;
          w_tag_n = w_tag;
          w_dst_n = w_dst;
          w_vc_n  = w_vc;
          w_cnt_n = CNT_W'(1);
          w_next  = (MAX_FLITS == 1) ? DISCARD
                                     : COLLECT;
        end
      endcase
    end
  end

  // Output is the MSB-aligned window of the chunk buffer.
  if (BUF_W >= WIDTH_DATA) begin : g_trunc
    assign w_data_n = w_buf_n[BUF_W-1 -: WIDTH_DATA];
  end else begin : g_pad
    assign w_data_n =
      {w_buf_n, {(WIDTH_DATA-BUF_W){1'b0}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_buf   <= '0;
      r_tag   <= '0;
      r_dst   <= '0;
      r_vc    <= '0;
      r_data  <= '0;
      r_dst_o <= '0;
      r_vc_o  <= '0;
      r_tag_o <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_n;
      r_buf   <= w_buf_n;
      r_tag   <= w_tag_n;
      r_dst   <= w_dst_n;
      r_vc    <= w_vc_n;
      if (w_load) begin
        r_data  <= w_data_n;
        r_dst_o <= w_dst_n;
        r_vc_o  <= w_vc_n;
        r_tag_o <= w_tag_n;
      end
    end
  end

`ifdef DEPACKETIZER_DTA_ERR_EN
  logic        w_err;
  logic        r_err;
  logic [15:0] r_err_cnt;

  // Stray flit, abandoned partial, or overflow.
  assign w_err =
    (w_start & !w_head) |
    (w_start & w_head & (r_state == COLLECT)) |
    (w_start & w_head & !w_tail &
     (MAX_FLITS == 1)) |
    (w_acc & !w_head & !w_tail &
     (r_state == COLLECT) &
     (w_cnt_inc == CNT_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_err <= w_err;
      if (w_err && r_err_cnt != 16'hFFFF)
        r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_out       = r_err;
  assign err_count_out = r_err_cnt;
`endif

endmodule

// File: tb/tb_depacketizer_dta_n.sv
// Randomized scoreboard bench for depacketizer_dta_n.
// Builds with or without DEPACKETIZER_DTA_ERR_EN.
module tb_depacketizer_dta_n;

  localparam int W    = 36;
  localparam int WD   = 99;
  localparam int AW   = 4;
  localparam int VW   = 1;
  localparam int TW   = 8;
  localparam int MAXF = 4;
  localparam int FD   = 28;
  localparam int HC   = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  data_in;
  logic          ready_out;
  logic [WD-1:0] data_out;
  logic [AW-1:0] dst_out;
  logic [VW-1:0] vc_out;
  logic [TW-1:0] tag_out;
  logic          valid_out;
  logic          ready_in;
`ifdef DEPACKETIZER_DTA_ERR_EN
  logic          err_out;
  logic [15:0]   err_count_out;
`endif

  always #5 clk = ~clk;

  depacketizer_dta_n dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .ready_out    (ready_out),
    .data_out     (data_out),
    .dst_out      (dst_out),
    .vc_out       (vc_out),
    .tag_out      (tag_out),
    .valid_out    (valid_out),
`ifdef DEPACKETIZER_DTA_ERR_EN
    .err_out      (err_out),
    .err_count_out(err_count_out),
`endif
    .ready_in     (ready_in)
  );

  typedef struct {
    logic [WD-1:0] d;
    logic [AW-1:0] dst;
    logic [VW-1:0] vc;
    logic [TW-1:0] tag;
  } pkt_t;

  pkt_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: packet as a list of chunks.
  bit            holding  = 0;
  bit            dropping = 0;
  int            ncur     = 0;
  logic [HC-1:0] m_c0;
  logic [FD-1:0] m_body[$];
  logic [TW-1:0] m_tag;
  logic [AW-1:0] m_dst;
  logic [VW-1:0] m_vc;
  int            m_errs   = 0;
  bit            m_pulse  = 0;
  bit            exp_valid = 0;
  bit            exp_ready = 1;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%0h exp=%0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(
    input bit v, input bit h, input bit t,
    input logic [FD-1:0] pl);
    logic [AW+VW-1:0] r;
    r = (AW+VW)'($urandom);
    return {v, h, t, r, pl};
  endfunction

  function automatic logic [FD-1:0] hd(
    input logic [TW-1:0] tg, input logic [AW-1:0] ds,
    input logic [VW-1:0] vc, input logic [HC-1:0] c0);
    return {tg, ds, vc, c0};
  endfunction

  function automatic logic [WD-1:0] ref_data();
    logic [255:0] a;
    int len;
    a = 256'(m_c0);
    len = HC;
    foreach (m_body[i]) begin
      a = (a << FD) | 256'(m_body[i]);
      len += FD;
    end
    if (len >= WD) a = a >> (len - WD);
    else           a = a << (WD - len);
    return a[WD-1:0];
  endfunction

  task automatic m_err();
    m_pulse = 1;
    if (m_errs < 65535) m_errs++;
  endtask

  task automatic m_finish();
    pkt_t p;
    p.d = ref_data();
    p.dst = m_dst;
    p.vc = m_vc;
    p.tag = m_tag;
    sb.push_back(p);
    holding = 1;
    ncur = 0;
  endtask

  task automatic model_step(input logic [W-1:0] f,
                            input bit rdy);
    bit v, h, t, acc;
    logic [FD-1:0] pl;
    v = f[W-1]; h = f[W-2]; t = f[W-3];
    pl = f[FD-1:0];
    m_pulse = 0;
    acc = v && (!holding || rdy);
    if (holding && rdy) holding = 0;
    if (acc) begin
      if (h) begin
        if (ncur > 0) m_err();
        dropping = 0;
        m_tag = pl[FD-1 -: TW];
        m_dst = pl[FD-TW-1 -: AW];
        m_vc  = pl[HC +: VW];
        m_c0  = pl[HC-1:0];
        m_body.delete();
        ncur = 1;
        if (t) m_finish();
      end else if (ncur > 0) begin
        if (t) begin
          m_body.push_back(pl);
          m_finish();
        end else if (ncur + 1 == MAXF) begin
          ncur = 0;
          dropping = 1;
          m_err();
        end else begin
          m_body.push_back(pl);
          ncur++;
        end
      end else if (dropping) begin
        if (t) dropping = 0;
      end else begin
        m_err();
      end
    end
  endtask

  task automatic step(input logic [W-1:0] f,
                      input bit rdy);
    data_in = f;
    ready_in = rdy;
    exp_valid = holding;
    exp_ready = !holding || rdy;
    @(posedge clk);
    model_step(f, rdy);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    holding = 0; dropping = 0; ncur = 0;
    sb.delete(); m_body.delete();
    m_errs = 0; m_pulse = 0;
    exp_valid = 0; exp_ready = 1;
    #1;
    chk("rst_valid", 128'(valid_out), 128'(0));
    chk("rst_data",  128'(data_out),  128'(0));
    chk("rst_dst",   128'(dst_out),   128'(0));
    chk("rst_vc",    128'(vc_out),    128'(0));
    chk("rst_tag",   128'(tag_out),   128'(0));
    chk("rst_rdy",   128'(ready_out), 128'(1));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("valid_out", 128'(valid_out), 128'(exp_valid));
      chk("ready_out", 128'(ready_out), 128'(exp_ready));
      if (valid_out) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_pkt act=%0h exp=none",
                   data_out);
        end else begin
          chk("data_out", 128'(data_out), 128'(sb[0].d));
          chk("dst_out",  128'(dst_out),  128'(sb[0].dst));
          chk("vc_out",   128'(vc_out),   128'(sb[0].vc));
          chk("tag_out",  128'(tag_out),  128'(sb[0].tag));
          if (ready_in) void'(sb.pop_front());
        end
      end
`ifdef DEPACKETIZER_DTA_ERR_EN
      chk("err_out", 128'(err_out), 128'(m_pulse));
      chk("err_count", 128'(err_count_out),
          128'(m_errs));
`endif
    end
  end

  logic [W-1:0] idle;
  logic [W-1:0] hb;

  initial begin
    rst = 1'b1;
    data_in = '0;
    ready_in = 1'b1;
    idle = '0;
    do_reset();

    step(mk(1, 1, 1,
            hd(8'hA5, 4'h3, 1'b1, 15'h1234)), 1);
    step(idle, 1);
    step(idle, 1);

    step(mk(1, 1, 0, hd(8'h3C, 4'h9, 1'b0,
                        15'h7ABC)), 0);
    step(mk(1, 0, 0, 28'hFEDCBA9), 0);
    step(mk(1, 0, 0, 28'h0123456), 0);
    step(mk(1, 0, 1, 28'hA5A5A5A), 0);
    hb = mk(1, 1, 1, hd(8'h11, 4'h2, 1'b1, 15'h0F0F));
    repeat (5) step(hb, 0);
    step(hb, 1);
    step(idle, 1);
    step(idle, 1);

    step(mk(1, 1, 0, hd(8'h22, 4'h4, 1'b0,
                        15'h1111)), 1);
    step(mk(1, 0, 0, 28'h2222222), 1);
    step(mk(1, 1, 1, hd(8'h33, 4'h5, 1'b1,
                        15'h3333)), 1);
    step(idle, 1);
    step(idle, 1);

    step(mk(1, 1, 0, hd(8'h44, 4'h6, 1'b0,
                        15'h4444)), 1);
    repeat (4) step(mk(1, 0, 0, 28'h5555555), 1);
    step(mk(1, 0, 1, 28'h6666666), 1);
    step(mk(1, 0, 1, 28'h7777777), 1);
    step(mk(1, 1, 1, hd(8'h55, 4'h7, 1'b0,
                        15'h5555)), 1);
    step(idle, 1);
    step(idle, 1);

    step(mk(1, 1, 0, hd(8'h66, 4'h8, 1'b1,
                        15'h6666)), 1);
    step(mk(1, 0, 0, 28'h8888888), 1);
    do_reset();
    step(mk(1, 1, 1, hd(8'h77, 4'hA, 1'b1,
                        15'h7777)), 1);
    step(idle, 1);
    step(idle, 1);

    for (int i = 0; i < 3000; i++) begin
      step(mk($urandom_range(0, 99) < 85,
              $urandom_range(0, 99) < 30,
              $urandom_range(0, 99) < 40,
              FD'($urandom)),
           $urandom_range(0, 99) < 70);
    end

    repeat (5) step(idle, 1);
    chk("sb_empty", 128'(sb.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d",
             n_checks, n_errors);
    $finish;
  end

endmodule
